pipe_stage_chain: RTL

//  Parametrised elastic pipeline-latch chain for the MIPS datapath. It replaces
//  the fixed, stall-less IF/ID, ID/EX and EX/MEM latches.

---
 rtl/pipe_stage_chain.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-latch chain: carries a data word and a control bundle
// through DEPTH stages with a valid/ready handshake. Empty stages take new
// entries even while stages further down are stalled. A synchronous flush
// kills every in-flight entry.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 9,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  occupancy
);

  // Per-stage state. Stage 0 is next to the input. Stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]  v;
  logic [WIDTH-1:0]  d [DEPTH];
  logic [CTRL_W-1:0] c [DEPTH];

  // r[i]: stage i may load from the stage before it this cycle.
  logic [DEPTH:0]    r;

  logic              take_in;
  logic              take_out;

  // Ready chain: stage i can advance when it is empty or everything past it moves.
  // Flattened to "out_ready, or some stage at or past i is empty" so that no
  // bit of r depends on another bit of r.
  assign r[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ready
    assign r[i] = out_ready | ~(&v[DEPTH-1:i]);
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_ctrl  = c[DEPTH-1];

  assign take_in  = in_valid & r[0];
  assign take_out = v[DEPTH-1] & out_ready;

  // Stage registers: reset clears all state. Flush clears valid and control
  // but keeps the data. Otherwise each ready stage loads from its predecessor.
  // A bubble always loads ctrl=0 so that it never commits a write downstream.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its predecessor's pre-edge value and the shift is exact.
    if (rst) begin
      v <= '0;
      // NOTE: the data registers are reset as well, because out_data must read
      // 0 after reset. Leave other payload arrays unreset when nothing
      // observes them.
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
      end
    end else begin
      if (r[0]) begin
        v[0] <= in_valid;
        d[0] <= in_data;
        c[0] <= in_valid ? in_ctrl : '0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
          c[i] <= v[i-1] ? c[i-1] : '0;
        end
      end
    end
  end

  // Occupancy counter: +1 on an accepted input, -1 on a delivered output,
  // unchanged when both happen. Cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      unique case ({take_in, take_out})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
